// File: rtl/sram_mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM data controller.
//   SRAM_DQ_W     : external SRAM data bus width (one half-word)
//   DATA_W        : pipeline data/address width
//   DEF_*         : default build parameters of sram_mem_ctrl
//   state_t       : controller sequence IDLE -> LO -> HI -> DONE
//   mem_req_t     : request captured from the EXE/MEM register when an access starts
package sram_mem_ctrl_pkg;

    localparam int unsigned SRAM_DQ_W     = 16;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned DEF_ADDR_W    = 18;
    localparam int unsigned DEF_WAIT_CYC  = 2;
    localparam int unsigned DEF_BASE_ADDR = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic              is_wr;
        logic [DATA_W-1:0] address;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// Pipeline-side request/response bundle of the MEM-stage SRAM controller.
//   rd_en, wr_en : load / store request from the EXE/MEM register
//   address      : byte address (ALU result)
//   wdata        : store data
//   rdata        : load data, valid while ready=1 after a load
//   ready        : 1 = no access in flight, 0 = freeze the pipeline
// master = pipeline side, slave = controller side.
interface sram_mem_ctrl_if import sram_mem_ctrl_pkg::*; ();

    logic              rd_en;
    logic              wr_en;
    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (
        output rd_en, wr_en, address, wdata,
        input  rdata, ready
    );

    modport slave (
        input  rd_en, wr_en, address, wdata,
        output rdata, ready
    );

endinterface

// File: rtl/sram_mem_ctrl.sv
// MEM-stage data controller: turns one 32-bit load/store into two 16-bit
// accesses on an asynchronous SRAM (low half first), each lasting WAIT_CYC
// cycles, and drops ready while busy so the pipeline freezes.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   bus (slave)        : rd_en, wr_en, address, wdata -> rdata, ready
//   SRAM_DQ            : bidirectional data, driven only during write phases
//   SRAM_ADDR          : half-word address {word, half}
//   SRAM_WE_N/OE_N     : write strobe / output enable, active low
//   SRAM_CE_N/UB_N/LB_N: tied low (chip and both bytes always selected)
module sram_mem_ctrl import sram_mem_ctrl_pkg::*; #(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned WAIT_CYC  = DEF_WAIT_CYC,
    parameter int unsigned BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram_mem_ctrl_if.slave       bus,
    inout  wire  [SRAM_DQ_W-1:0] SRAM_DQ,
    output logic [ADDR_W-1:0]    SRAM_ADDR,
    output logic                 SRAM_WE_N,
    output logic                 SRAM_OE_N,
    output logic                 SRAM_CE_N,
    output logic                 SRAM_UB_N,
    output logic                 SRAM_LB_N
);

    localparam int unsigned    CNT_W    = $clog2(WAIT_CYC);
    localparam int unsigned    WORD_W   = ADDR_W - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYC - 1);

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;

    mem_req_t             req_q;
    mem_req_t             req_src;
    logic                 req_c;
    logic                 phase_last_c;
    logic [DATA_W-1:0]    offs_c;
    logic [WORD_W-1:0]    word_c;
    logic                 unused_offs;

    logic                 we_n_d;
    logic                 oe_n_d;
    logic                 dq_oe_d;
    logic                 dq_oe_q;
    logic [ADDR_W-1:0]    addr_d;
    logic [SRAM_DQ_W-1:0] dq_out_d;
    logic [SRAM_DQ_W-1:0] dq_out_q;
    logic [DATA_W-1:0]    rdata_q;

    assign req_c        = bus.rd_en | bus.wr_en;
    assign phase_last_c = (cnt_q == CNT_LAST);

    // Request as seen this cycle: live inputs while idle, captured copy once started
    always_comb begin
        req_src = req_q;
        if (state_q == ST_IDLE) begin
            req_src.is_wr   = bus.wr_en;
            req_src.address = bus.address;
            req_src.wdata   = bus.wdata;
        end
    end

    // Byte address -> SRAM word; out-of-range addresses simply wrap
    assign offs_c      = req_src.address - DATA_W'(BASE_ADDR);
    assign word_c      = offs_c[ADDR_W:2];
    assign unused_offs = ^{offs_c[DATA_W-1:ADDR_W+1], offs_c[1:0]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: each half-word phase runs cnt 0..WAIT_CYC-1
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_c) state_d = ST_LO;
            end
            ST_LO: begin
                if (phase_last_c) state_d = ST_HI;
                else              cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_HI: begin
                if (phase_last_c) state_d = ST_DONE;
                else              cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // SRAM pin values for the coming cycle, derived from the next state so the
    // registered pins line up with the phase they belong to. WE_N rises on the
    // last cycle of a write phase while address and data are still held.
    always_comb begin
        we_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        dq_oe_d  = 1'b0;
        addr_d   = SRAM_ADDR;
        dq_out_d = dq_out_q;
        if (state_d == ST_LO || state_d == ST_HI) begin
            addr_d = {word_c, (state_d == ST_HI)};
            if (req_src.is_wr) begin
                dq_oe_d  = 1'b1;
                dq_out_d = (state_d == ST_HI) ? req_src.wdata[DATA_W-1:SRAM_DQ_W]
                                              : req_src.wdata[SRAM_DQ_W-1:0];
                we_n_d   = (cnt_d == CNT_LAST);
            end else begin
                oe_n_d = 1'b0;
            end
        end
    end

    // Request capture, SRAM pin registers and load data latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            dq_oe_q   <= 1'b0;
            dq_out_q  <= '0;
            rdata_q   <= '0;
        end else begin
            if (state_q == ST_IDLE && req_c) begin
                req_q <= req_src;
            end
            SRAM_ADDR <= addr_d;
            SRAM_WE_N <= we_n_d;
            SRAM_OE_N <= oe_n_d;
            dq_oe_q   <= dq_oe_d;
            dq_out_q  <= dq_out_d;
            if (phase_last_c && !req_q.is_wr) begin
                if (state_q == ST_LO) rdata_q[SRAM_DQ_W-1:0]      <= SRAM_DQ;
                if (state_q == ST_HI) rdata_q[DATA_W-1:SRAM_DQ_W] <= SRAM_DQ;
            end
        end
    end

    assign SRAM_DQ   = dq_oe_q ? dq_out_q : {SRAM_DQ_W{1'bz}};
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign bus.rdata = rdata_q;
    // Combinational so a dropped (flushed) request releases the pipeline at once
    assign bus.ready = (state_q == ST_DONE) || (state_q == ST_IDLE && !req_c);

endmodule
